// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: one shared runtime prescaler produces a tick, and
// each channel runs its own OFF/ON/TOGGLE/ONESHOT mode with a period in ticks.
module led_blink_multi #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int PRESCALE_W   = 16,
    parameter int PERIOD_W     = 8,
    parameter int RESET_PERIOD = 0
) (
    input  logic                  clk,
    input  logic                  btn,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic [PERIOD_W-1:0]   cfg_period,
    output logic                  tick,
    output logic [NUM_CH-1:0]     led
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_TOGGLE  = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    logic [PRESCALE_W-1:0] pre_q;
    logic                  tick_q;

    mode_t               mode_q   [NUM_CH];
    mode_t               mode_d   [NUM_CH];
    logic [PERIOD_W-1:0] period_q [NUM_CH];
    logic [PERIOD_W-1:0] period_d [NUM_CH];
    logic [PERIOD_W-1:0] cnt_q    [NUM_CH];
    logic [PERIOD_W-1:0] cnt_d    [NUM_CH];
    logic [NUM_CH-1:0]   led_q;
    logic [NUM_CH-1:0]   led_d;

    // The >= compare makes a lowered prescale wrap on the next edge.
    always_ff @(posedge clk) begin
        if (btn) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else if (pre_q >= prescale) begin
            pre_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            pre_q  <= pre_q + PRESCALE_W'(1);
            tick_q <= 1'b0;
        end
    end

    // cfg_we is a one-cycle strobe with no ready: a write to a valid channel is
    // always accepted at the edge it is sampled and overrides that edge's tick.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            led_d[i]    = led_q[i];
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                mode_d[i]   = mode_t'(cfg_mode);
                period_d[i] = cfg_period;
                cnt_d[i]    = '0;
                led_d[i]    = (cfg_mode != 2'd0);
            end else if (tick_q) begin
                case (mode_q[i])
                    MODE_TOGGLE: begin
                        if (cnt_q[i] >= period_q[i]) begin
                            cnt_d[i] = '0;
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q[i] >= period_q[i]) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = 1'b0;
                            mode_d[i] = MODE_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                        end
                    end
                    default: cnt_d[i] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (btn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= MODE_TOGGLE;
                period_q[i] <= PERIOD_W'(RESET_PERIOD);
                cnt_q[i]    <= '0;
            end
            led_q <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            led_q <= led_d;
        end
    end

    assign tick = tick_q;
    assign led  = led_q;

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench for led_blink_multi: a 4-channel instance for the main
// sequences and a 3-channel instance for out-of-range channel writes.
module tb_led_blink_multi;

    logic        clk;
    logic        btn;
    logic [15:0] prescale;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_period;
    logic        tick;
    logic [3:0]  led;

    logic        btn3;
    logic [15:0] prescale3;
    logic        cfg_we3;
    logic [1:0]  cfg_ch3;
    logic [1:0]  cfg_mode3;
    logic [7:0]  cfg_period3;
    logic        tick3;
    logic [2:0]  led3;

    int checks = 0;
    int errors = 0;

    led_blink_multi #(.NUM_CH(4), .CH_W(2), .PRESCALE_W(16), .PERIOD_W(8), .RESET_PERIOD(0)) dut (
        .clk(clk), .btn(btn), .prescale(prescale), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .tick(tick), .led(led)
    );

    led_blink_multi #(.NUM_CH(3), .CH_W(2), .PRESCALE_W(16), .PERIOD_W(8), .RESET_PERIOD(0)) dut3 (
        .clk(clk), .btn(btn3), .prescale(prescale3), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
        .cfg_mode(cfg_mode3), .cfg_period(cfg_period3), .tick(tick3), .led(led3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] per);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
    endtask

    initial begin
        btn = 1'b1; prescale = 16'd3;
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_mode = 2'd0; cfg_period = 8'd0;
        btn3 = 1'b1; prescale3 = 16'hFFFF;
        cfg_we3 = 1'b0; cfg_ch3 = 2'd0; cfg_mode3 = 2'd0; cfg_period3 = 8'd0;

        // reset, prescale=3, period 0: tick every 4th edge, all LEDs toggle per tick
        step(2);
        check("rst_tick", tick, 0);
        check("rst_led", led, 4'hF);
        check("rst_led3", led3, 3'h7);
        btn = 1'b0; btn3 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check("pre_no_tick", tick, 0);
        end
        step(1); check("first_tick", tick, 1); check("led_e4", led, 4'hF);
        step(1); check("tick_e5", tick, 0);    check("led_e5", led, 4'h0);
        step(3); check("tick_e8", tick, 1);    check("led_e8", led, 4'h0);
        step(1); check("led_e9", led, 4'hF);
        step(4); check("led_e13", led, 4'h0);
        step(4); check("led_e17", led, 4'hF);

        // ch1 TOGGLE period 2 with prescale=0 (tick every cycle)
        prescale = 16'd0;
        write(2'd1, 2'd2, 8'd2);
        step(1); check("p2_a_led", led, 4'hF); check("p2_a_tick", tick, 1);
        cfg_we = 1'b0;
        step(1); check("p2_b", led, 4'h2);
        step(1); check("p2_c", led, 4'hF);
        step(1); check("p2_d", led, 4'h0);
        step(1); check("p2_e", led, 4'hD);
        step(1); check("p2_f", led, 4'h0);
        step(1); check("p2_g", led, 4'hF);

        // ch2 ONESHOT period 4, prescale=1: high for 5 ticks (10 edges), then OFF
        prescale = 16'd1;
        write(2'd2, 2'd3, 8'd4);
        step(1); check("os_write", led[2], 1); check("os_tick_h", tick, 0);
        cfg_we = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            check("os_high", led[2], 1);
        end
        step(1); check("os_low", led[2], 0); check("os_tick_r", tick, 0);
        step(2); check("os_stays_off", led[2], 0);
        write(2'd2, 2'd2, 8'd0);
        step(1); check("os_retoggle_u", led[2], 1);
        cfg_we = 1'b0;
        step(1); check("os_retoggle_v", led[2], 0);
        step(1); check("os_retoggle_w", led[2], 0);
        step(1); check("os_retoggle_x", led[2], 1);

        // ch0 OFF then ON; out-of-range writes on the 3-channel instance
        write(2'd0, 2'd0, 8'd0);
        cfg_we3 = 1'b1; cfg_ch3 = 2'd0; cfg_mode3 = 2'd0; cfg_period3 = 8'd0;
        step(1); check("off_led0", led[0], 0); check("v3_off", led3, 3'h6);
        cfg_we = 1'b0;
        cfg_ch3 = 2'd3; cfg_mode3 = 2'd0;
        step(1); check("off_hold", led[0], 0); check("v3_bad_off", led3, 3'h6);
        write(2'd0, 2'd1, 8'd0);
        cfg_mode3 = 2'd1; cfg_period3 = 8'd7;
        step(1); check("on_led0", led[0], 1); check("v3_bad_on", led3, 3'h6);
        cfg_we = 1'b0; cfg_we3 = 1'b0;
        step(1); check("on_hold", led[0], 1);
        check("v3_tick", tick3, 0); check("v3_led_final", led3, 3'h6);

        // write on ch3 landing on the tick edge: ch3 restarts, ch0..2 toggle
        btn = 1'b1;
        step(1); check("rst2_led", led, 4'hF); check("rst2_tick", tick, 0);
        btn = 1'b0; prescale = 16'd3;
        step(3); check("rst2_e3", tick, 0);
        step(1); check("rst2_e4", tick, 1);
        write(2'd3, 2'd2, 8'd0);
        step(1); check("coll_e5", led, 4'h8);
        cfg_we = 1'b0;
        step(4); check("coll_e9", led, 4'h7);

        // reset during a ONESHOT with a simultaneous write: write discarded
        write(2'd2, 2'd3, 8'd4);
        step(1); check("os2_start", led, 4'h7);
        cfg_we = 1'b0;
        step(1);
        btn = 1'b1;
        write(2'd0, 2'd0, 8'd5);
        step(1); check("rst3_led", led, 4'hF); check("rst3_tick", tick, 0);
        btn = 1'b0; cfg_we = 1'b0;
        step(3); check("rst3_e3", tick, 0);
        step(1); check("rst3_e4", tick, 1); check("rst3_led_e4", led, 4'hF);
        step(1); check("rst3_e5", led, 4'h0);
        step(4); check("rst3_e9", led, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_blink_multi.md
Name: led_blink_multi

Overview:
- Parametrised multi-channel successor to the single-LED synchronous toggler.
- One shared runtime-programmable prescaler generates a one-cycle tick.
- Each of NUM_CH channels has its own mode (OFF / ON / TOGGLE / ONESHOT) and its own period, counted in ticks, written through a simple per-channel config port.
- Sits between board-level control logic and the LED pins.

Parameters:
- NUM_CH, 4, number of LED channels (>=1).
- CH_W, 2, width of cfg_ch; must satisfy 2**CH_W >= NUM_CH.
- PRESCALE_W, 16, width of prescaler counter and prescale input.
- PERIOD_W, 8, width of per-channel period and tick counter.
- RESET_PERIOD, 0, per-channel period loaded on reset.

Ports:
- clk  in  1  system clock; all logic on posedge.
- btn  in  1  reset; synchronous, active-high.
- prescale  in  PRESCALE_W  tick interval minus one; static or quasi-static.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_mode  in  2  0=OFF, 1=ON, 2=TOGGLE, 3=ONESHOT.
- cfg_period  in  PERIOD_W  ticks per phase.
- tick  out  1  registered prescaler tick, one cycle wide.
- led  out  NUM_CH  registered LED outputs.

Behaviour:
- Reset (btn=1 at posedge; dominates cfg_we): pre_q=0, tick=0, all channels mode=TOGGLE, period=RESET_PERIOD, cnt=0, led=all ones.
- Prescaler: each non-reset edge, if pre_q >= prescale then pre_q<=0 and tick<=1; else pre_q<=pre_q+1 and tick<=0.
  - tick period = prescale+1 cycles; prescale=0 gives tick high every cycle.
  - First tick is high after the (prescale+1)th edge following reset release.
  - Using >= means lowering prescale below pre_q wraps on the next edge; there is no runaway.
- Config write (cfg_we=1, cfg_ch < NUM_CH), applied at the edge:
  - mode<=cfg_mode, period<=cfg_period, cnt<=0.
  - led<=0 for OFF, led<=1 for ON/TOGGLE/ONESHOT; visible the cycle after the write edge.
  - cfg_ch >= NUM_CH: write ignored, no state change.
- Per-channel update on edges where tick_q=1, channel not being written:
  - OFF / ON: led held; cnt held at 0.
  - TOGGLE: if cnt >= period then cnt<=0 and led<=~led; else cnt<=cnt+1. The LED therefore toggles every period+1 ticks, and period=0 toggles every tick.
  - ONESHOT: if cnt >= period then cnt<=0, led<=0, mode<=OFF; else cnt<=cnt+1. The LED stays high for exactly period+1 ticks, then the channel self-reverts to OFF.
- Simultaneous write and tick on the same channel: the write wins and that tick is not counted for that channel. Other channels process the tick normally.
- cnt arithmetic is PERIOD_W bits. The >= compare guarantees wrap at period, so cnt never overflows.
- Reset asserted mid-sequence: all state returns to reset values at that edge. A pending oneshot is abandoned and led returns to 1.
- Outputs are purely registered; there is no combinational path from inputs to led or tick.

Test Plan:
- Reset, prescale=3, RESET_PERIOD=0 -> tick high on every 4th cycle, first at edge 4 after release; all led start at 1 and all toggle on each tick (4 ticks = 2 full blink cycles).
- Write ch1 TOGGLE, period=2, prescale=0 -> led[1]=1 next cycle, then toggles every 3 cycles; other channels keep their phase.
- Write ch2 ONESHOT, period=4, prescale=1 -> led[2]=1 for 5 ticks (10 cycles ±1 for tick alignment), then 0; a readback-by-behaviour write of ch2 TOGGLE afterwards restarts blinking.
- Write ch0 OFF then ON; write cfg_ch=3 with NUM_CH=3 -> led[0]=0 then 1; the invalid write changes nothing.
- cfg_we on ch3 aligned exactly with tick -> ch3 cnt=0 and led=1 after the edge; ch0..2 advance normally.
- btn asserted for 1 cycle during a ONESHOT, with cfg_we=1 in the same cycle -> reset state everywhere: led=all ones, TOGGLE mode, write discarded.
